ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Bootstrap sequencer directly upstream of the 256x8 main RAM. It drives the RAM's write-enable, write-data and address inputs and reads back its combinational data output.
- Accepts a byte stream from a host over a valid/ready handshake and either writes it sequentially into RAM (LOAD) or compares it against RAM contents (VERIFY).
- Reports a running checksum, a completion pulse and the first mismatch address.

Parameters:
- AW, 8, RAM address width; RAM depth is 2^AW.
- DW, 8, data width.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request to begin a transfer; sampled in IDLE only.
- MODE  in  1  0 = LOAD, 1 = VERIFY; sampled with START.
- BASE  in  AW  first RAM address; sampled with START.
- LEN  in  AW+1  byte count, 0..256; sampled with START.
- IN_VALID  in  1  host byte valid.
- IN_DATA  in  DW  host byte.
- IN_READY  out  1  loader can accept a byte.
- RAM_WE  out  1  to RAM write enable.
- RAM_WD  out  DW  to RAM write data.
- RAM_ADDR  out  AW  to RAM read/write address.
- RAM_D  in  DW  from RAM read data (combinational on RAM_ADDR).
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  verify mismatch seen; sticky until the next accepted START.
- ERR_ADDR  out  AW  address of the first mismatch.
- CKSUM  out  DW  sum mod 2^DW of all accepted bytes in the current or last transfer.

Behaviour:
- Reset (async): state IDLE; all outputs 0, including RAM_WE, RAM_ADDR, RAM_WD, CKSUM, ERR, ERR_ADDR. RAM contents are untouched.
  - Reset mid-transfer drops RAM_WE immediately. The byte in flight may or may not be written; this is not specified.
- States: IDLE, LOAD, VERIFY. All outputs are registered except IN_READY, which equals (state==LOAD || state==VERIFY).
- IDLE + START:
  - RAM_ADDR <= BASE, CKSUM <= 0, ERR <= 0, ERR_ADDR <= 0.
  - Remaining count <= min(LEN, 256).
  - If LEN == 0: stay IDLE, pulse DONE next cycle, BUSY stays 0.
  - Else: go to LOAD or VERIFY per MODE, BUSY <= 1.
- START outside IDLE is ignored.
- Accept: IN_VALID && IN_READY at posedge. Each accept adds the byte to CKSUM (mod 256) and decrements the remaining count.
- LOAD accept at posedge k:
  - RAM_WE <= 1, RAM_WD <= IN_DATA, RAM_ADDR <= current write address.
  - RAM_WE/RAM_WD/RAM_ADDR are held stable through the falling edge of cycle k, when the RAM commits the write.
  - RAM_WE <= 0 at posedge k+1 unless that edge is another accept.
  - Back-to-back accepts write one byte per cycle.
  - Internal write address advances +1, wrapping 255 -> 0.
- VERIFY accept:
  - RAM_WE stays 0.
  - RAM_ADDR already points at the current address; compare RAM_D with IN_DATA.
  - On mismatch while ERR == 0: ERR <= 1, ERR_ADDR <= RAM_ADDR.
  - RAM_ADDR <= RAM_ADDR + 1 (wraps). Remaining bytes are still consumed after an error.
- Last accept (remaining == 1):
  - Next state IDLE, BUSY <= 0, DONE <= 1 for exactly one cycle.
  - In LOAD, RAM_WE for the final byte is high in the same cycle as DONE.
- IN_VALID with no accept (IDLE) has no effect. IN_VALID low in LOAD/VERIFY stalls with no writes.
- Address wrap: BASE = 0xF0, LEN = 32 writes 0xF0..0xFF then 0x00..0x0F.
- LEN > 256 is clamped to 256.
- START and a final accept cannot coincide: START is only honoured in IDLE.

Test Plan:
- Reset, then LOAD with BASE=0x10, LEN=4, bytes 01 02 03 04 streamed back-to-back -> RAM[0x10..0x13] = 01..04; RAM_WE high 4 consecutive cycles; DONE one pulse the cycle after the 4th accept; CKSUM = 0x0A.
- LOAD with BASE=0xFE, LEN=3, bytes AA BB CC with IN_VALID gaps -> RAM[FE]=AA, RAM[FF]=BB, RAM[00]=CC; no writes during gap cycles; CKSUM = 0x31.
- VERIFY on the first region, bytes 01 02 FF 04 -> ERR=1, ERR_ADDR=0x12, all 4 bytes consumed, DONE pulses, CKSUM = 0x06. A following VERIFY with matching data (01 02 03 04) -> ERR cleared at START and stays 0.
- START with LEN=0 -> BUSY stays 0, DONE pulses once, RAM unchanged. A second START asserted during an active LOAD -> ignored; BASE, LEN and CKSUM are unaffected.
- Assert RST during a LOAD after 2 of 4 bytes -> all outputs 0 asynchronously; RAM[BASE], RAM[BASE+1] hold the written values. A subsequent transfer runs normally.
- LEN=256, BASE=0x80, bytes i=0..255 -> every RAM location written with (i) at address 0x80+i mod 256; CKSUM = 0x80; DONE once.

Source files
------------

// File: rtl/ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_if
// Description : Bundle of host handshake, RAM bus and status signals for the
//               RAM bootstrap loader. Names are from the loader's viewpoint.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_loader_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          i_start;
    logic          i_mode;
    logic [AW-1:0] i_base;
    logic [AW:0]   i_len;
    logic          i_in_valid;
    logic [DW-1:0] i_in_data;
    logic          o_in_ready;
    logic          o_ram_we;
    logic [DW-1:0] o_ram_wd;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] i_ram_d;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [AW-1:0] o_err_addr;
    logic [DW-1:0] o_cksum;

    // Loader side
    modport slave (
        input  i_start, i_mode, i_base, i_len, i_in_valid, i_in_data, i_ram_d,
        output o_in_ready, o_ram_we, o_ram_wd, o_ram_addr,
               o_busy, o_done, o_err, o_err_addr, o_cksum
    );

    // Host / RAM side
    modport master (
        output i_start, i_mode, i_base, i_len, i_in_valid, i_in_data, i_ram_d,
        input  o_in_ready, o_ram_we, o_ram_wd, o_ram_addr,
               o_busy, o_done, o_err, o_err_addr, o_cksum
    );
endinterface
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Bootstrap sequencer in front of the main RAM. Streams host
//               bytes into RAM (LOAD) or compares them against RAM (VERIFY),
//               keeping a running checksum and the first mismatch address.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    ram_loader_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2
    } state_t;

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    state_t        w_next_state;
    logic [AW:0]   r_cnt;
    logic [AW-1:0] r_waddr;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wd;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [AW-1:0] r_err_addr;
    logic [DW-1:0] r_cksum;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_start;
    logic [AW:0]   w_len_clamped;

    assign w_in_ready    = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign w_accept      = bus.i_in_valid && w_in_ready;
    assign w_last        = w_accept && (r_cnt == (AW+1)'(1));
    assign w_start       = (r_state == S_IDLE) && bus.i_start;
    assign w_len_clamped = (bus.i_len > c_DEPTH) ? c_DEPTH : bus.i_len;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a zero-length request never leaves IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && (w_len_clamped != '0)) begin
                    w_next_state = bus.i_mode ? S_VERIFY : S_LOAD;
                end
            end
            S_LOAD, S_VERIFY: begin
                if (w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: RAM bus, count, checksum and error capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_waddr    <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wd       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_cksum    <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_start) begin
                r_addr     <= bus.i_base;
                r_waddr    <= bus.i_base;
                r_cksum    <= '0;
                r_err      <= 1'b0;
                r_err_addr <= '0;
                r_cnt      <= w_len_clamped;
                if (w_len_clamped == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                end
            end
            if (w_accept) begin
                r_cksum <= r_cksum + bus.i_in_data;
                r_cnt   <= r_cnt - (AW+1)'(1);
                if (r_state == S_LOAD) begin
                    // Bus stays stable until the RAM commits on the falling edge
                    r_we    <= 1'b1;
                    r_wd    <= bus.i_in_data;
                    r_addr  <= r_waddr;
                    r_waddr <= r_waddr + AW'(1);
                end else begin
                    // r_addr already addresses the byte being compared
                    if ((bus.i_ram_d != bus.i_in_data) && !r_err) begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                    end
                    r_addr <= r_addr + AW'(1);
                end
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.o_in_ready = w_in_ready;
    assign bus.o_ram_we   = r_we;
    assign bus.o_ram_wd   = r_wd;
    assign bus.o_ram_addr = r_addr;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;
    assign bus.o_err_addr = r_err_addr;
    assign bus.o_cksum    = r_cksum;
endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_loader
// Description : Scoreboard bench for ram_loader with a behavioural RAM and a
//               reference memory image used to predict writes and results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;
    logic clk;
    logic rst;

    ram_loader_if #(.AW(8), .DW(8)) bus ();

    ram_loader #(.AW(8), .DW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the falling edge
    logic [7:0] mem [256];
    assign bus.i_ram_d = mem[bus.o_ram_addr];
    always @(negedge clk) begin
        if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wd;
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0] cksum;
        logic       err;
        logic [7:0] err_addr;
    } done_t;

    wr_t        exp_wr[$];
    done_t      exp_done[$];
    logic [7:0] ref_mem [256];
    logic [7:0] tx_bytes[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write and every DONE pulse is matched to the model
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_ram_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", int'(bus.o_ram_addr), int'(w.addr));
                    check("wr_data", int'(bus.o_ram_wd), int'(w.data));
                end
            end
            if (bus.o_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("cksum", int'(bus.o_cksum), int'(d.cksum));
                    check("err", int'(bus.o_err), int'(d.err));
                    check("err_addr", int'(bus.o_err_addr), int'(d.err_addr));
                    check("busy_at_done", int'(bus.o_busy), 0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, int'(bus.o_in_ready), 0);
        check({tag, "_we"}, int'(bus.o_ram_we), 0);
        check({tag, "_wd"}, int'(bus.o_ram_wd), 0);
        check({tag, "_addr"}, int'(bus.o_ram_addr), 0);
        check({tag, "_busy"}, int'(bus.o_busy), 0);
        check({tag, "_done"}, int'(bus.o_done), 0);
        check({tag, "_err"}, int'(bus.o_err), 0);
        check({tag, "_erraddr"}, int'(bus.o_err_addr), 0);
        check({tag, "_cksum"}, int'(bus.o_cksum), 0);
    endtask

    // Present one byte until it is accepted; returns after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
        bit acc;
        int t;
        if (gaps) begin
            bus.i_in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = b;
        if (poke) begin
            bus.i_start = 1'b1;
            bus.i_mode  = ~bus.i_mode;
            bus.i_base  = bus.i_base + 8'h33;
            bus.i_len   = 9'd7;
        end
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = bus.o_in_ready;
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            t++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        bus.i_in_valid = 1'b0;
    endtask

    // Issue a transfer from tx_bytes; n_send < length means abort by reset
    task automatic run_xfer(input bit mode, input int base, input int len,
                            input int n_send, input bit gaps, input bit poke);
        int    n;
        done_t d;
        bit    found;
        n = (len > 256) ? 256 : len;
        d = '0;
        found = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            int a;
            a = (base + i) % 256;
            d.cksum = d.cksum + tx_bytes[i];
            if (!mode) begin
                exp_wr.push_back('{addr: 8'(a), data: tx_bytes[i]});
                ref_mem[a] = tx_bytes[i];
            end else if (!found && ref_mem[a] != tx_bytes[i]) begin
                found      = 1'b1;
                d.err      = 1'b1;
                d.err_addr = 8'(a);
            end
        end
        if (n_send == n) exp_done.push_back(d);

        bus.i_start = 1'b1;
        bus.i_mode  = mode;
        bus.i_base  = 8'(base);
        bus.i_len   = 9'(len);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        if (n == 0) begin
            check("len0_done", int'(bus.o_done), 1);
            check("len0_busy", int'(bus.o_busy), 0);
            check("len0_ready", int'(bus.o_in_ready), 0);
        end else begin
            check("start_busy", int'(bus.o_busy), 1);
            for (int i = 0; i < n_send; i++) begin
                send_byte(tx_bytes[i], gaps, poke && (i == 1));
            end
            if (n_send == n) begin
                check("done_after_last", int'(bus.o_done), 1);
                check("busy_after_last", int'(bus.o_busy), 0);
            end
        end
        if (n_send == n) begin
            @(posedge clk);
            #1;
            check("done_one_cycle", int'(bus.o_done), 0);
            for (int t = 0; t < 20 && exp_done.size() != 0; t++) @(posedge clk);
            if (exp_done.size() != 0) begin
                check("done_timeout", 0, 1);
                exp_done.delete();
            end
        end
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_mode     = 1'b0;
        bus.i_base     = '0;
        bus.i_len      = '0;
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LOAD 0x10, 01..04 back-to-back
        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_xfer(1'b0, 'h10, 4, 4, 1'b0, 1'b0);
        check("load1_cksum", int'(bus.o_cksum), 'h0A);

        // LOAD across the top of memory with stalls
        tx_bytes = '{8'hAA, 8'hBB, 8'hCC};
        run_xfer(1'b0, 'hFE, 3, 3, 1'b1, 1'b0);
        check("load2_cksum", int'(bus.o_cksum), 'h31);

        // VERIFY with a mismatch at 0x12; ERR must stay after completion
        tx_bytes = '{8'h01, 8'h02, 8'hFF, 8'h04};
        run_xfer(1'b1, 'h10, 4, 4, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("err_sticky", int'(bus.o_err), 1);
        check("err_addr_held", int'(bus.o_err_addr), 'h12);
        check("verify_cksum", int'(bus.o_cksum), 'h06);

        // Matching VERIFY clears ERR
        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_xfer(1'b1, 'h10, 4, 4, 1'b1, 1'b0);
        check("err_cleared", int'(bus.o_err), 0);

        // Zero-length request
        tx_bytes = {};
        run_xfer(1'b0, 'h40, 0, 0, 1'b0, 1'b0);

        // LOAD with a START poked mid-transfer
        tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_xfer(1'b0, 'h60, 5, 5, 1'b0, 1'b1);

        // Reset after 2 of 4 LOAD bytes
        tx_bytes = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
        run_xfer(1'b0, 'hC0, 4, 2, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (exp_wr.size() != 0) check("wr_left_after_reset", exp_wr.size(), 0);
        exp_wr.delete();

        // Transfer after reset, then full 256-byte wrap with oversize LEN
        tx_bytes = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
        run_xfer(1'b1, 'hC0, 2, 2, 1'b0, 1'b0);
        tx_bytes = {};
        for (int i = 0; i < 256; i++) tx_bytes.push_back(8'(i));
        run_xfer(1'b0, 'h80, 256, 256, 1'b0, 1'b0);
        check("full_cksum", int'(bus.o_cksum), 'h80);
        run_xfer(1'b1, 'h80, 300, 256, 1'b1, 1'b0);

        // Randomised LOAD / VERIFY transfers
        for (int k = 0; k < 12; k++) begin
            int  base;
            int  len;
            bit  mode;
            base = $urandom_range(0, 255);
            len  = $urandom_range(1, 40);
            mode = 1'($urandom_range(0, 1));
            tx_bytes = {};
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = mode ? ref_mem[(base + i) % 256] : 8'($urandom);
                if (mode && $urandom_range(0, 7) == 0) b = b ^ 8'h5C;
                tx_bytes.push_back(b);
            end
            run_xfer(mode, base, len, len, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(posedge clk);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("ram_image_diffs", diffs, 0);
        check("writes_pending", exp_wr.size(), 0);
        check("dones_pending", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
